// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Holds the program counter and, on a
//                one-cycle fetch request from the control unit, performs a
//                valid/ready read on the instruction bus (address channel,
//                then data channel). The returned word is latched and
//                announced to the decoder with a one-cycle inst_valid strobe.
//  Ports       :
//    clk              - clock, all state changes on the rising edge
//    rst              - asynchronous active-low reset
//    inst_fetch       - fetch request pulse from the control unit
//    pc_en / pc_next  - load pc from pc_next this cycle
//    pc               - current program counter
//    inst             - last fetched instruction (held between fetches)
//    inst_valid       - one-cycle strobe: inst updated this cycle
//    fetch_busy       - fetch in flight (address or data phase)
//    fetch_misaligned - one-cycle strobe: request refused, pc[1:0] != 0
//    ir_addr_*        - instruction bus address channel (valid/ready)
//    ir_data_*        - instruction bus data channel (valid/ready)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_fetch,
  input  logic                  pc_en,
  input  logic [PC_WIDTH-1:0]   pc_next,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  fetch_busy,
  output logic                  fetch_misaligned,
  output logic                  ir_addr_valid,
  input  logic                  ir_addr_ready,
  output logic [PC_WIDTH-1:0]   ir_addr,
  input  logic                  ir_data_valid,
  output logic                  ir_data_ready,
  input  logic [INST_WIDTH-1:0] ir_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   r_fetch_addr;
  logic [INST_WIDTH-1:0] r_inst;
  logic                  r_inst_valid;
  logic                  r_misaligned;
  logic                  r_addr_valid;
  logic                  r_data_ready;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_data_hs;

  // Next-state logic. Requests arriving outside IDLE are dropped, not queued.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_misaligned = 1'b0;
    w_data_hs    = 1'b0;
    case (r_state)
      IDLE: begin
        if (inst_fetch) begin
          if (r_pc[1:0] == 2'b00) begin
            w_accept    = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_misaligned = 1'b1;
          end
        end
      end
      REQ: begin
        if (r_addr_valid && ir_addr_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (ir_data_valid && r_data_ready) begin
          w_data_hs   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus strobes are registered from the next state so they line up exactly
  // with the state they belong to, without combinational paths to the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_ADDR;
      r_fetch_addr <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_misaligned <= 1'b0;
      r_addr_valid <= 1'b0;
      r_data_ready <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr_valid <= (w_state_nxt == REQ);
      r_data_ready <= (w_state_nxt == WAIT);
      r_busy       <= (w_state_nxt != IDLE);
      r_inst_valid <= w_data_hs;
      r_misaligned <= w_misaligned;
      if (w_data_hs) begin
        r_inst <= ir_data;
      end
      // The fetch address is captured from the current pc, so a pc_en in the
      // same cycle only affects the following fetch.
      if (w_accept) begin
        r_fetch_addr <= r_pc;
      end
      if (pc_en) begin
        r_pc <= pc_next;
      end
    end
  end

  assign pc               = r_pc;
  assign inst             = r_inst;
  assign inst_valid       = r_inst_valid;
  assign fetch_busy       = r_busy;
  assign fetch_misaligned = r_misaligned;
  assign ir_addr_valid    = r_addr_valid;
  assign ir_addr          = r_fetch_addr;
  assign ir_data_ready    = r_data_ready;

endmodule
`default_nettype wire
